stopwatch_tick_counter: RTL

Consumer end of the stopwatch timebase. Receives the 10 Hz toggling timebase (each level transition marks 100 ms) and resynchronises it into the 50 MHz domain. It also debounce-free edge-detects the start/stop, lap and clear buttons, and maintains an MM:SS.t BCD count from 00:00.0 to 59:59.9. Its outputs feed the seven-segment display driver directly.

---
 rtl/stopwatch_tick_counter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/stopwatch_tick_counter.sv
// stopwatch_tick_counter: resynchronises the 10 Hz timebase and the three
// buttons into the clk_in domain and keeps an MM:SS.t BCD count with a lap
// snapshot. Display outputs drive the seven-segment driver directly.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | count zeroed, waiting for start_stop
// RUN   | counting, display shows live count
// LAP   | counting, display frozen on lap registers
// PAUSE | count held, clear returns to IDLE
module stopwatch_tick_counter #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [3:0] tenths,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_PAUSE} state_t;

  state_t state;

  // bit 0 tick, bit 1 start_stop, bit 2 lap, bit 3 clear
  logic [3:0] raw;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] prev_q;
  logic [3:0] last;
  logic       tick_evt, ss_evt, lap_evt, clr_evt;

  logic [3:0] live_t, live_so, live_mo;
  logic [2:0] live_st, live_mt;
  logic [3:0] lap_t, lap_so, lap_mo;
  logic [2:0] lap_st, lap_mt;
  logic [3:0] nxt_t, nxt_so, nxt_mo;
  logic [2:0] nxt_st, nxt_mt;
  logic       nxt_wrap;
  logic       counting;

  assign raw  = {btn_clear, btn_lap, btn_start_stop, tick_in};
  assign last = sync_q[SYNC_STAGES-1];

  // Input synchronisers plus previous-value register for edge detection
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      prev_q <= last;
    end
  end

  // Tick fires on either timebase edge; buttons on rising edge only
  assign tick_evt = last[0] ^ prev_q[0];
  assign ss_evt   = last[1] & ~prev_q[1];
  assign lap_evt  = last[2] & ~prev_q[2];
  assign clr_evt  = last[3] & ~prev_q[3];

  assign counting = (state == S_RUN) || (state == S_LAP);

  // Live count plus one, BCD cascade with rollover at 59:59.9
  always_comb begin
    nxt_t    = live_t;
    nxt_so   = live_so;
    nxt_st   = live_st;
    nxt_mo   = live_mo;
    nxt_mt   = live_mt;
    nxt_wrap = 1'b0;
    if (live_t != 4'd9) nxt_t = live_t + 4'd1;
    else begin
      nxt_t = 4'd0;
      if (live_so != 4'd9) nxt_so = live_so + 4'd1;
      else begin
        nxt_so = 4'd0;
        if (live_st != 3'd5) nxt_st = live_st + 3'd1;
        else begin
          nxt_st = 3'd0;
          if (live_mo != 4'd9) nxt_mo = live_mo + 4'd1;
          else begin
            nxt_mo = 4'd0;
            if (live_mt != 3'd5) nxt_mt = live_mt + 3'd1;
            else begin
              nxt_mt   = 3'd0;
              nxt_wrap = 1'b1;
            end
          end
        end
      end
    end
  end

  // Control FSM, live/lap registers and registered status outputs
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      running    <= 1'b0;
      lap_active <= 1'b0;
      wrap       <= 1'b0;
      {live_t, live_so, live_st, live_mo, live_mt} <= '0;
      {lap_t, lap_so, lap_st, lap_mo, lap_mt}      <= '0;
    end else begin
      wrap <= 1'b0;
      // the tick is judged against the state before any transition
      if (counting && tick_evt) begin
        {live_t, live_so, live_st, live_mo, live_mt} <= {nxt_t, nxt_so, nxt_st, nxt_mo, nxt_mt};
        wrap <= nxt_wrap;
      end
      case (state)
        S_IDLE: begin
          if (ss_evt) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
        S_RUN: begin
          if (ss_evt) begin
            state   <= S_PAUSE;
            running <= 1'b0;
          end else if (lap_evt) begin
            state      <= S_LAP;
            lap_active <= 1'b1;
            if (tick_evt)
              {lap_t, lap_so, lap_st, lap_mo, lap_mt} <= {nxt_t, nxt_so, nxt_st, nxt_mo, nxt_mt};
            else
              {lap_t, lap_so, lap_st, lap_mo, lap_mt} <= {live_t, live_so, live_st, live_mo, live_mt};
          end
        end
        S_LAP: begin
          if (ss_evt) begin
            state      <= S_PAUSE;
            running    <= 1'b0;
            lap_active <= 1'b0;
          end else if (lap_evt) begin
            state      <= S_RUN;
            lap_active <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (clr_evt) begin
            state <= S_IDLE;
            {live_t, live_so, live_st, live_mo, live_mt} <= '0;
            {lap_t, lap_so, lap_st, lap_mo, lap_mt}      <= '0;
          end else if (ss_evt) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign tenths   = lap_active ? lap_t  : live_t;
  assign sec_ones = lap_active ? lap_so : live_so;
  assign sec_tens = lap_active ? lap_st : live_st;
  assign min_ones = lap_active ? lap_mo : live_mo;
  assign min_tens = lap_active ? lap_mt : live_mt;

endmodule
